// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Asynchronous serial transmitter. Sends a start bit, LSB-first
//             data, optional parity and 1 or 2 stop bits; the line idles high.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  c_data_last = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  c_stop_last = CNT_W'(STOP_BITS - 1);
   localparam logic              c_odd       = (PARITY_ODD != 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           r_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx_out;
   logic                 r_tx_busy;
   logic                 r_tx_done;
   logic                 w_bit_end;

   assign w_bit_end = (r_baud == c_baud_last);

   assign tx_out  = r_tx_out;
   assign tx_busy = r_tx_busy;
   assign tx_done = r_tx_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx_out  <= 1'b1;
         r_tx_busy <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;

         // Baud counter free-runs only while a frame is on the line.
         if (r_state == S_IDLE || w_bit_end) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_tx_out  <= 1'b1;
               r_tx_busy <= 1'b0;
               r_bit_cnt <= '0;
               if (tx_start) begin
                  r_shift   <= tx_data;
                  r_parity  <= (^tx_data) ^ c_odd;
                  r_state   <= S_START;
                  r_tx_out  <= 1'b0;
                  r_tx_busy <= 1'b1;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_tx_out  <= r_shift[0];
                  r_bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_cnt == c_data_last) begin
                     r_bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        r_state  <= S_PARITY;
                        r_tx_out <= r_parity;
                     end else begin
                        r_state  <= S_STOP;
                        r_tx_out <= 1'b1;
                     end
                  end else begin
                     // shift[1] is the next bit, since the shift lands this same edge
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_tx_out  <= r_shift[1];
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state   <= S_STOP;
                  r_tx_out  <= 1'b1;
                  r_bit_cnt <= '0;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == c_stop_last) begin
                     r_state   <= S_IDLE;
                     r_tx_busy <= 1'b0;
                     r_tx_done <= 1'b1;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_tx_out  <= 1'b1;
               r_tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Scoreboard bench for uart_tx over four frame formats.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

   localparam int         CPB        = 4;
   localparam logic [3:0] PEN_MASK   = 4'b0110;
   localparam logic [3:0] ODD_MASK   = 4'b0100;
   localparam logic [3:0] STOP2_MASK = 4'b1000;
   localparam logic [31:0] DIR0      = 32'hFF_07_07_A5;
   localparam logic [31:0] DIR1      = 32'h00_3C_A5_5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fin    = 0;

   task automatic check(input string name, input bit ok,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Line level for each bit slot of a frame; slot 0 is the start bit.
   function automatic logic [15:0] ref_frame(input logic [7:0] d, input int pen,
                                             input int odd);
      logic [15:0] v;
      v    = '1;
      v[0] = 1'b0;
      for (int i = 0; i < 8; i++) v[1+i] = d[i];
      if (pen != 0) v[9] = ((($countones(d) + odd) % 2) == 1);
      return v;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_inst
      localparam int         PEN   = int'(PEN_MASK[g]);
      localparam int         ODD   = int'(ODD_MASK[g]);
      localparam int         STOPS = STOP2_MASK[g] ? 2 : 1;
      localparam int         NBITS = 9 + PEN + STOPS;
      localparam logic [7:0] D0    = DIR0[g*8 +: 8];
      localparam logic [7:0] D1    = DIR1[g*8 +: 8];

      logic       rst;
      logic       start;
      logic [7:0] data;
      logic       out;
      logic       busy;
      logic       done;
      logic [7:0] exp_q[$];

      uart_tx #(
         .CLKS_PER_BIT(CPB),
         .DATA_BITS   (8),
         .PARITY_EN   (PEN),
         .PARITY_ODD  (ODD),
         .STOP_BITS   (STOPS)
      ) dut (
         .clk     (clk),
         .rst     (rst),
         .tx_start(start),
         .tx_data (data),
         .tx_out  (out),
         .tx_busy (busy),
         .tx_done (done)
      );

      // mode 0: quiet, 1: start held high, 2: start+data poke in bit 3, 3: random noise
      task automatic send(input logic [7:0] d, input int mode);
         start = 1'b1;
         data  = d;
         @(posedge clk); #1;
         exp_q.push_back(d);
         for (int k = 0; k < NBITS*CPB; k++) begin
            case (mode)
               0: start = 1'b0;
               1: start = 1'b1;
               2: begin
                  start = (k == 16);
                  if (k == 16) data = 8'hFF;
               end
               default: begin
                  start = 1'($urandom_range(0, 1));
                  data  = 8'($urandom);
               end
            endcase
            @(posedge clk); #1;
         end
         start = 1'b0;
      endtask

      task automatic gap(input int n);
         repeat (n) begin
            @(posedge clk); #1;
         end
      endtask

      initial begin : drv
         rst   = 1'b1;
         start = 1'b0;
         data  = 8'h00;
         @(negedge clk);
         check($sformatf("reset_state_%0d", g), out === 1'b1 && busy === 1'b0 && done === 1'b0,
               32'({out, busy, done}), 32'b100);
         @(posedge clk); #1 rst = 1'b0;

         send(D0, 0); gap(2);
         send(D1, 0); gap(3);
         send(8'h55, 1); send(8'h0F, 1); gap(2);
         send(8'h3C, 2); gap(6);

         // Abandon a frame part-way through data bit 5.
         start = 1'b1;
         data  = 8'($urandom);
         @(posedge clk); #1 start = 1'b0;
         exp_q.push_back(data);
         repeat (25) @(posedge clk);
         #3 rst = 1'b1;
         #1;
         check($sformatf("async_reset_%0d", g), out === 1'b1 && busy === 1'b0 && done === 1'b0,
               32'({out, busy, done}), 32'b100);
         exp_q.delete();
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         gap(1);
         send(8'h81, 0); gap(2);

         for (int n = 0; n < 30; n++) begin
            send(8'($urandom), 3);
            gap(int'($urandom_range(0, 3)));
         end
         gap(5);
         check($sformatf("queue_drained_%0d", g), exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
         n_fin++;
      end

      initial begin : mon
         logic [15:0] bits;
         logic [7:0]  d;
         int          errs;
         bit          aborted;
         forever begin
            @(negedge clk);
            if (rst) continue;
            if (!busy) begin
               check($sformatf("idle_line_%0d", g), out === 1'b1 && done === 1'b0,
                     32'({out, done}), 32'b10);
            end else if (exp_q.size() == 0) begin
               check($sformatf("unexpected_frame_%0d", g), 1'b0, 32'(busy), 32'd0);
               while (busy && !rst) @(negedge clk);
            end else begin
               d       = exp_q.pop_front();
               bits    = ref_frame(d, PEN, ODD);
               errs    = 0;
               aborted = 1'b0;
               for (int i = 0; i < NBITS*CPB; i++) begin
                  if (i > 0) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (out !== bits[i/CPB] || busy !== 1'b1 || done !== 1'b0) errs++;
               end
               if (!aborted) begin
                  check($sformatf("frame_%0d_%02h", g, d), errs == 0, 32'(errs), 32'd0);
                  @(negedge clk);
                  if (!rst)
                     check($sformatf("done_pulse_%0d", g),
                           done === 1'b1 && busy === 1'b0 && out === 1'b1,
                           32'({done, busy, out}), 32'b101);
               end
            end
         end
      end
   end

   initial begin : ctl
      wait (n_fin == 4);
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      n_checks++;
      $display("FAIL timeout: drivers finished %0d, expected 4", n_fin);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
